// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage controller for a word-only data memory (big-endian lanes, RMW sub-word stores).
// Define LSU_PERF_EN to add saturating perf_loads/perf_stores counters.
module load_store_unit #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0080,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write
`ifdef LSU_PERF_EN
    ,
    output logic [15:0] perf_loads,
    output logic [15:0] perf_stores
`endif
);
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;
    localparam logic [31:0] WIN = 32'(4 * MEM_WORDS);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RESP} state_t;
    state_t r_state, w_next;
    logic [2:0]  r_op;
    logic [31:0] r_addr, r_wdata, r_word, r_rdata;
    logic        r_err;
    logic        w_accept, w_misal, w_oow, w_err;
    logic [31:0] w_off, w_ld, w_mask, w_ins, w_merged;
    logic [4:0]  w_sh8, w_sh16;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_accept = req_valid & req_ready;
    assign w_misal  = (req_op == LW || req_op == SW) ? |req_addr[1:0] :
                      (req_op == LH || req_op == LHU || req_op == SH) ? req_addr[0] : 1'b0;
    assign w_off    = req_addr - MEM_BASE;
    assign w_oow    = (req_addr < MEM_BASE) || (w_off >= WIN);
    assign w_err    = w_misal | w_oow;
    // Big-endian lanes: offset 0 is the most significant byte, so shift by (3-offset) lanes.
    assign w_sh8    = {~r_addr[1:0], 3'b000};
    assign w_sh16   = {~r_addr[1], 4'b0000};
    assign w_byte   = 8'(mem_rdata >> w_sh8);
    assign w_half   = 16'(mem_rdata >> w_sh16);
    assign w_ld     = r_op == LW  ? mem_rdata :
                      r_op == LH  ? {{16{w_half[15]}}, w_half} :
                      r_op == LHU ? {16'b0, w_half} :
                      r_op == LB  ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
    assign w_mask   = r_op == SB ? 32'h0000_00FF << w_sh8 : 32'h0000_FFFF << w_sh16;
    assign w_ins    = r_op == SB ? 32'(r_wdata[7:0]) << w_sh8 : 32'(r_wdata[15:0]) << w_sh16;
    assign w_merged = (r_word & ~w_mask) | w_ins;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_err ? RESP : req_op < SW ? RD : req_op == SW ? WR : RMW_RD;
            RD:      w_next = RESP;
            RMW_RD:  w_next = WR;
            WR:      w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = (r_state == IDLE) & ~rst;
        mem_read   = ~rst & (r_state == RD || r_state == RMW_RD);
        mem_write  = ~rst & (r_state == WR);
        mem_addr   = (r_state == RD || r_state == WR || r_state == RMW_RD) ? {r_addr[31:2], 2'b00} : 32'h0;
        mem_wdata  = r_state == WR ? (r_op == SW ? r_wdata : w_merged) : 32'h0;
        resp_valid = ~rst & (r_state == RESP);
        resp_rdata = resp_valid ? r_rdata : 32'h0;
        resp_err   = resp_valid & r_err;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= LW;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_word  <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_err;
                r_rdata <= 32'h0;
            end
            if (r_state == RD)     r_rdata <= w_ld;
            if (r_state == RMW_RD) r_word  <= mem_rdata;
        end
    end
`ifdef LSU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads  <= 16'h0;
            perf_stores <= 16'h0;
        end else if (r_state == RESP && !r_err) begin
            if (r_op < SW) perf_loads  <= perf_loads + {15'b0, ~&perf_loads};
            else           perf_stores <= perf_stores + {15'b0, ~&perf_stores};
        end
    end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
`ifdef LSU_PERF_EN
    logic [15:0] perf_loads, perf_stores;
`endif
    int total = 0, bad = 0;
    int rd_cnt = 0, wr_cnt = 0;
    int exp_loads = 0, exp_stores = 0;
    logic [31:0] tbmem [0:31];
    logic [31:0] w_d;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = 5'd0;
    logic [31:0] pl_dat = 32'h0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write)
`ifdef LSU_PERF_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores)
`endif
    );

    always #5 clk = ~clk;

    // Data_Memory model: word index addr/4-32, combinational read, write on the clock edge.
    assign w_d = mem_addr - 32'h80;
    assign mem_rdata = tbmem[w_d[6:2]];
    always @(posedge clk) begin
        if (pl_en) tbmem[pl_idx] <= pl_dat;
        else if (mem_write) tbmem[w_d[6:2]] <= mem_wdata;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic preload(input int idx, input logic [31:0] val);
        pl_idx = 5'(idx); pl_dat = val; pl_en = 1'b1;
        @(posedge clk); #1 pl_en = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int lat;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL %s ready: got %b want 1", nm, req_ready); end
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1 lat++;
        end
        total++;
        if (lat !== exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
        total++;
        if (resp_rdata !== exp_rd) begin bad++; $display("FAIL %s rdata: got %h want %h", nm, resp_rdata, exp_rd); end
        total++;
        if (resp_err !== exp_err) begin bad++; $display("FAIL %s err: got %b want %b", nm, resp_err, exp_err); end
        @(posedge clk); #1;
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL %s pulse: resp_valid got %b want 0", nm, resp_valid); end
        if (!exp_err) begin
            if (op < 3'd5) exp_loads++;
            else exp_stores++;
        end
    endtask

    task automatic chk_cnt(input int r0, input int w0, input int dr, input int dw, input string nm);
        total++;
        if (rd_cnt - r0 !== dr) begin bad++; $display("FAIL %s mem_read count: got %0d want %0d", nm, rd_cnt - r0, dr); end
        total++;
        if (wr_cnt - w0 !== dw) begin bad++; $display("FAIL %s mem_write count: got %0d want %0d", nm, wr_cnt - w0, dw); end
    endtask

    task automatic chk_word(input int idx, input logic [31:0] exp, input string nm);
        total++;
        if (tbmem[idx] !== exp) begin bad++; $display("FAIL %s mem word: got %h want %h", nm, tbmem[idx], exp); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL reset req_ready: got %b want 0", req_ready); end
        total++;
        if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0) begin
            bad++; $display("FAIL reset strobes: got %b want 0000", {resp_valid, resp_err, mem_read, mem_write});
        end
        total++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            bad++; $display("FAIL reset data: got %h %h %h want 0", resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset release req_ready: got %b want 1", req_ready); end
        exp_loads = 0; exp_stores = 0;
    endtask

    task automatic test_loads;
        int r0, w0;
        preload(1, 32'h8899AABB);
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(3'd0, 32'h84, 32'h0, 2, 32'h8899AABB, 1'b0, "LW 84");
        do_req(3'd3, 32'h85, 32'h0, 2, 32'hFFFFFF99, 1'b0, "LB 85");
        do_req(3'd4, 32'h85, 32'h0, 2, 32'h00000099, 1'b0, "LBU 85");
        do_req(3'd1, 32'h86, 32'h0, 2, 32'hFFFFAABB, 1'b0, "LH 86");
        do_req(3'd2, 32'h84, 32'h0, 2, 32'h00008899, 1'b0, "LHU 84");
        do_req(3'd3, 32'h87, 32'h0, 2, 32'hFFFFFFBB, 1'b0, "LB 87");
        do_req(3'd4, 32'h84, 32'h0, 2, 32'h00000088, 1'b0, "LBU 84");
        do_req(3'd1, 32'h84, 32'h0, 2, 32'hFFFF8899, 1'b0, "LH 84");
        chk_cnt(r0, w0, 8, 0, "loads");
    endtask

    task automatic test_stores;
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(3'd7, 32'h87, 32'h00000012, 3, 32'h0, 1'b0, "SB 87");
        chk_word(1, 32'h8899AA12, "SB 87");
        chk_cnt(r0, w0, 1, 1, "SB 87");
        do_req(3'd7, 32'h84, 32'hFFFFFFAB, 3, 32'h0, 1'b0, "SB 84");
        chk_word(1, 32'hAB99AA12, "SB 84");
        preload(3, 32'h11223344);
        do_req(3'd6, 32'h8E, 32'hFFFF5566, 3, 32'h0, 1'b0, "SH 8E");
        chk_word(3, 32'h11225566, "SH 8E");
        do_req(3'd6, 32'h8C, 32'h00007788, 3, 32'h0, 1'b0, "SH 8C");
        chk_word(3, 32'h77885566, "SH 8C");
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(3'd5, 32'h88, 32'hDEADBEEF, 2, 32'h0, 1'b0, "SW 88");
        chk_word(2, 32'hDEADBEEF, "SW 88");
        chk_cnt(r0, w0, 0, 1, "SW 88");
        do_req(3'd0, 32'h88, 32'h0, 2, 32'hDEADBEEF, 1'b0, "LW 88");
        do_req(3'd5, 32'hFC, 32'hCAFEF00D, 2, 32'h0, 1'b0, "SW FC");
        chk_word(31, 32'hCAFEF00D, "SW FC");
        do_req(3'd3, 32'hFF, 32'h0, 2, 32'h0000000D, 1'b0, "LB FF");
    endtask

    task automatic test_errors;
        int r0, w0;
        preload(0, 32'h01020304);
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(3'd0, 32'h82, 32'h0, 1, 32'h0, 1'b1, "LW 82");
        do_req(3'd5, 32'h100, 32'hFFFFFFFF, 1, 32'h0, 1'b1, "SW 100");
        do_req(3'd1, 32'h85, 32'h0, 1, 32'h0, 1'b1, "LH 85");
        do_req(3'd6, 32'h87, 32'h1111, 1, 32'h0, 1'b1, "SH 87");
        do_req(3'd0, 32'h7C, 32'h0, 1, 32'h0, 1'b1, "LW 7C");
        do_req(3'd4, 32'h7F, 32'h0, 1, 32'h0, 1'b1, "LBU 7F");
        do_req(3'd0, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1'b1, "LW FFFFFFFC");
        do_req(3'd7, 32'h100, 32'hAA, 1, 32'h0, 1'b1, "SB 100");
        chk_cnt(r0, w0, 0, 0, "errors");
        chk_word(0, 32'h01020304, "SW 100 untouched");
        do_req(3'd4, 32'h80, 32'h0, 2, 32'h00000001, 1'b0, "LBU 80");
    endtask

    task automatic test_reset_mid;
        int w0;
        preload(1, 32'h8899AABB);
        w0 = wr_cnt;
        req_op = 3'd6; req_addr = 32'h84; req_wdata = 32'h5566; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_write !== 1'b1) begin bad++; $display("FAIL rst-mid WR cycle: mem_write got %b want 1", mem_write); end
        rst = 1'b1;
        #1;
        total++;
        if (mem_write !== 1'b0) begin bad++; $display("FAIL rst-mid gating: mem_write got %b want 0", mem_write); end
        @(posedge clk); #1 rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst-mid req_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst-mid resp_valid: got %b want 0", resp_valid); end
            @(posedge clk); #1;
        end
        chk_word(1, 32'h8899AABB, "rst-mid");
        total++;
        if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL rst-mid writes: got %0d want 0", wr_cnt - w0); end
        exp_loads = 0; exp_stores = 0;
    endtask

    task automatic test_back_to_back;
        int lat;
        preload(2, 32'hDEADBEEF);
        req_op = 3'd0; req_addr = 32'h84; req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b busy req_ready: got %b want 0", req_ready); end
        req_op = 3'd4; req_addr = 32'h88;
        @(posedge clk); #1;
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899AABB) begin
            bad++; $display("FAIL b2b first resp: got %b %h want 1 8899aabb", resp_valid, resp_rdata);
        end
        @(posedge clk); #1;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL b2b idle: resp_valid %b req_ready %b want 0 1", resp_valid, req_ready);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1 lat++;
        end
        total++;
        if (lat !== 2 || resp_rdata !== 32'h000000DE) begin
            bad++; $display("FAIL b2b second resp: lat %0d rdata %h want 2 000000de", lat, resp_rdata);
        end
        @(posedge clk); #1;
        exp_loads += 2;
    endtask

`ifdef LSU_PERF_EN
    task automatic test_perf;
        do_req(3'd0, 32'h84, 32'h0, 2, 32'h8899AABB, 1'b0, "perf LW");
        do_req(3'd3, 32'h85, 32'h0, 2, 32'hFFFFFF99, 1'b0, "perf LB");
        do_req(3'd2, 32'h86, 32'h0, 2, 32'h0000AABB, 1'b0, "perf LHU");
        do_req(3'd5, 32'h100, 32'h0, 1, 32'h0, 1'b1, "perf SW err");
        total++;
        if (perf_loads !== 16'(exp_loads)) begin bad++; $display("FAIL perf_loads: got %0d want %0d", perf_loads, exp_loads); end
        total++;
        if (perf_stores !== 16'(exp_stores)) begin bad++; $display("FAIL perf_stores: got %0d want %0d", perf_stores, exp_stores); end
    endtask
`endif

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_errors;
        test_reset_mid;
        test_back_to_back;
`ifdef LSU_PERF_EN
        test_perf;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
